// File: rtl/data_sram_slave.sv
// data_sram_slave: in-order responder for the CPU data-side SRAM-like port.
// Requests are queued (up to FIFO_DEPTH outstanding), each entry counts down
// LATENCY-1 cycles, and the head entry answers with data_ok once its count is
// zero. Writes commit to the word memory at the head's data_ok edge, reads
// return the full aligned word on rdata in that same cycle.
//
// Parameters:
//   ADDR_W     word-index width, memory is 2^ADDR_W x 32 (ADDR_W <= 29)
//   LATENCY    minimum accept-to-data_ok distance in cycles, 1..15
//   FIFO_DEPTH maximum outstanding requests, power of two, <= 8
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   req, wr, size      request valid, write select, access size (unused)
//   wstrb, addr, wdata byte-lane enables, byte address, lane-aligned data
//   addr_ok            request accepted when req is also high
//   data_ok, rdata     in-order response strobe, read word (0 otherwise)
//
// Build option: define DATA_SRAM_SLAVE_RAND_DELAY_EN to gate addr_ok and
// data_ok with bits of a free-running 16-bit LFSR (random stalls).

module data_sram_slave #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned WORDS = 2 ** ADDR_W;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] idx;
        logic [3:0]        wstrb;
        logic [31:0]       wdata;
        logic [CNT_W-1:0]  cnt;
    } entry_t;

    // Word memory; deliberately not reset (preloaded by the environment).
    logic [31:0] mem [WORDS];

    entry_t           fifo_q [FIFO_DEPTH];
    entry_t           fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    entry_t head;
    logic   head_valid;
    logic   head_ready;
    logic   full;
    logic   push;
    logic   pop;

    // Size and the bits outside the word index carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{size, addr[1:0], addr[31:ADDR_W+2]};

    assign head       = fifo_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign head_ready = head_valid & (head.cnt == '0);
    assign full       = (count_q == OCC_W'(FIFO_DEPTH));

`ifdef DATA_SRAM_SLAVE_RAND_DELAY_EN
    // Fibonacci LFSR, taps 16,14,13,11, advancing every cycle.
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign addr_ok = ~full & lfsr_q[0];
    assign data_ok = head_ready & lfsr_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign addr_ok = ~full;
    assign data_ok = head_ready;
`endif

    assign push  = req & addr_ok;
    assign pop   = data_ok;
    assign rdata = (data_ok & ~head.wr) ? mem[head.idx] : 32'h0;

    // Pointer advance, modulo FIFO_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Next state: countdown of every slot, then push/pop bookkeeping.
    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        // Empty slots count down too; they are overwritten on push anyway.
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (fifo_q[i].cnt != '0) begin
                fifo_d[i].cnt = fifo_q[i].cnt - CNT_W'(1);
            end
        end

        if (push) begin
            fifo_d[wr_ptr_q].wr    = wr;
            fifo_d[wr_ptr_q].idx   = addr[ADDR_W+1:2];
            fifo_d[wr_ptr_q].wstrb = wstrb;
            fifo_d[wr_ptr_q].wdata = wdata;
            fifo_d[wr_ptr_q].cnt   = CNT_W'(LATENCY - 1);
            wr_ptr_d               = ptr_inc(wr_ptr_q);
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state register; reset discards every outstanding entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Writes commit at the head's response edge, lane by lane.
    always_ff @(posedge clk) begin
        if (pop & head.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (head.wstrb[i]) begin
                    mem[head.idx][8*i +: 8] <= head.wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave (default build): directed test-plan steps plus a
// randomized phase, checked every cycle against a timestamped transaction
// queue and a shadow word array.

module tb_data_sram_slave;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned LATENCY    = 2;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned WORDS      = 2 ** ADDR_W;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    data_sram_slave #(
        .ADDR_W    (ADDR_W),
        .LATENCY   (LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .wstrb  (wstrb),
        .addr   (addr),
        .wdata  (wdata),
        .addr_ok(addr_ok),
        .data_ok(data_ok),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        int unsigned idx;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int unsigned due;
    } txn_t;

    txn_t        q[$];
    logic [31:0] mref [WORDS];
    int unsigned cyc;
    int          errors;
    int          checks;
    int unsigned acc_cnt;
    int unsigned dok_cnt;
    int unsigned last_acc_cyc;
    int unsigned last_dok_cyc;
    logic [31:0] last_rdata;
    logic        took;

    function automatic logic [31:0] pre(input int unsigned i);
        return 32'(i) * 32'h9E37_79B1 + 32'h0F0F_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: compare outputs mid-cycle, advance the model, step the edge.
    task automatic tick();
        logic        exp_aok;
        logic        exp_dok;
        logic [31:0] exp_rd;
        txn_t        t;
        @(negedge clk);
        exp_aok = reset ? 1'b1 : (q.size() < FIFO_DEPTH);
        exp_dok = !reset && (q.size() > 0) && (cyc >= q[0].due);
        exp_rd  = (exp_dok && !q[0].wr) ? mref[q[0].idx] : 32'h0;
        chk("addr_ok", 32'(addr_ok), 32'(exp_aok));
        chk("data_ok", 32'(data_ok), 32'(exp_dok));
        chk("rdata", rdata, exp_rd);
        took = req && addr_ok && !reset;
        if (took) begin
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (data_ok) begin
            dok_cnt++;
            last_dok_cyc = cyc;
            if (q.size() > 0 && !q[0].wr) last_rdata = rdata;
        end
        if (reset) begin
            q.delete();
        end else begin
            if (exp_dok) begin
                t = q.pop_front();
                if (t.wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (t.wstrb[b]) mref[t.idx][8*b +: 8] = t.wdata[8*b +: 8];
                    end
                end
            end
            if (req && exp_aok) begin
                t.wr    = wr;
                t.idx   = (addr >> 2) % WORDS;
                t.wstrb = wstrb;
                t.wdata = wdata;
                t.due   = cyc + LATENCY;
                q.push_back(t);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wstrb = s;
        wdata = d;
        size  = 2'd2;
        took  = 1'b0;
        for (int i = 0; i < 20 && !took; i++) tick();
        chk("accept_timeout", 32'(took), 32'd1);
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        req = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    int unsigned saved_dok;

    initial begin
        errors = 0;  checks = 0;  cyc = 0;
        acc_cnt = 0; dok_cnt = 0; last_rdata = 32'h0;
        last_acc_cyc = 0; last_dok_cyc = 0; took = 1'b0;
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0;
        wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Preload memory and its shadow.
        for (int i = 0; i < int'(WORDS); i++) begin
            dut.mem[i] = pre(i);
            mref[i]    = pre(i);
        end
        dut.mem[4] = 32'h1122_3344;
        mref[4]    = 32'h1122_3344;

        // Reset state.
        idle(2);
        reset = 1'b0;
        idle(2);

        // Preloaded read: response exactly LATENCY cycles after accept.
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        idle(3);
        chk("preload_rdata", last_rdata, 32'h1122_3344);
        chk("read_latency", last_dok_cyc - last_acc_cyc, 32'(LATENCY));

        // Byte write then back-to-back read of the same word.
        issue(1'b1, 32'h13, 4'b1000, 32'hAB00_0000);
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        idle(4);
        chk("byte_write_rdata", last_rdata, 32'hAB22_3344);

        // Index wraps modulo 2^ADDR_W.
        issue(1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 32'h0000_0000, 4'h0, 32'h0);
        idle(4);
        chk("wrap_rdata", last_rdata, 32'hDEAD_BEEF);

        // A zero-strobe write is answered but leaves memory untouched.
        saved_dok = dok_cnt;
        issue(1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF);
        issue(1'b0, 32'h20, 4'h0, 32'h0);
        idle(4);
        chk("strb0_rdata", last_rdata, pre(8));
        chk("strb0_responses", dok_cnt - saved_dok, 32'd2);

        // Continuous requests: addr_ok drops while full, every accept answered.
        req = 1'b1; wr = 1'b0; wstrb = 4'h0; wdata = 32'h0;
        for (int i = 0; i < 12; i++) begin
            addr = 32'(i) << 2;
            tick();
        end
        drain();
        chk("full_acc_vs_dok", dok_cnt, acc_cnt);

        // Reset with two writes in flight: no responses, memory unchanged.
        issue(1'b1, 32'h40, 4'hF, 32'h5555_5555);
        issue(1'b1, 32'h44, 4'hF, 32'h6666_6666);
        saved_dok = dok_cnt;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(3);
        chk("reset_no_dok", dok_cnt, saved_dok);
        chk("reset_addr_ok", 32'(addr_ok), 32'd1);
        issue(1'b0, 32'h40, 4'h0, 32'h0);
        idle(3);
        chk("reset_mem16", last_rdata, pre(16));
        issue(1'b0, 32'h44, 4'h0, 32'h0);
        idle(3);
        chk("reset_mem17", last_rdata, pre(17));
        acc_cnt = 0;
        dok_cnt = 0;

        // Randomized traffic over a small, aliased address window.
        for (int i = 0; i < 600; i++) begin
            req   = ($urandom_range(0, 3) != 0);
            wr    = $urandom_range(0, 1) == 1;
            wstrb = 4'($urandom_range(0, 15));
            wdata = $urandom();
            size  = 2'($urandom_range(0, 2));
            addr  = (32'($urandom_range(0, 7)) << 12) |
                    (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            tick();
        end
        drain();
        chk("rand_acc_vs_dok", dok_cnt, acc_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_sram_slave.md
# data_sram_slave

Responder side of the SRAM-like data interface driven by the MEM/EXE load-store path. It accepts requests on `req`/`addr_ok`, queues up to `FIFO_DEPTH` outstanding transactions, and returns exactly one `data_ok` per accepted request, strictly in order, with `rdata` valid for reads. It sits between the CPU's data-side SRAM-like port and a behavioural word-organised memory. It serves as the bench memory model and as the reference responder for AXI-bridge verification.

## Interface
- `ADDR_W`, default 10: word-index width; memory holds 2^ADDR_W 32-bit words.
- `LATENCY`, default 2: minimum number of cycles from the accept cycle to the `data_ok` cycle; legal range 1..15.
- `FIFO_DEPTH`, default 2: maximum number of outstanding requests; must be a power of two, at most 8.
- `clk` input, 1 bit: sole clock; rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `req` input, 1 bit: request valid.
- `wr` input, 1 bit: 1 = write, 0 = read.
- `size` input, 2 bits: access size 0/1/2 = byte/half/word; informational only.
- `wstrb` input, 4 bits: byte-lane write enables.
- `addr` input, 32 bits: byte address.
- `wdata` input, 32 bits: write data, already lane-aligned.
- `addr_ok` output, 1 bit: request accepted this cycle when `req` is also high.
- `data_ok` output, 1 bit: response for the oldest outstanding request.
- `rdata` output, 32 bits: full aligned word; the CPU performs lane extraction and extension.

## Operation
- Accept: `req & addr_ok` at a rising edge pushes the entry {wr, idx = addr[ADDR_W+1:2], wstrb, wdata, cnt = LATENCY-1} into the FIFO.
  - `addr[1:0]` is ignored.
  - Upper address bits are ignored, so the index wraps modulo 2^ADDR_W.
- `addr_ok` = `~full`.
  - It does not depend on a pop in the same cycle, so it has no combinational path from `data_ok`.
  - When full, `addr_ok` = 0 even if the head pops that cycle.
- Every valid entry's `cnt` decrements each cycle and saturates at 0.
- `data_ok` = `head_valid & (head.cnt == 0)`; it is combinational from registered state.
- Pop happens on any edge where `data_ok` = 1.
  - Write: byte lane i of `mem[idx]` is updated where `wstrb[i]`; `rdata` = 0.
  - Read: `rdata` = `mem[head.idx]`.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Ordering: writes commit at their pop, so a later read of the same word returns the new data.
- A write with `wstrb` = 0 still returns `data_ok` and leaves memory unchanged.
- No cancellation exists: every accepted request receives exactly one `data_ok`. The requester discards unwanted responses.
- Memory contents are not reset. The bench preloads them via hierarchical initialisation.

## Timing
- Reset values: `addr_ok` = 1 (FIFO empty); `data_ok` = 0; `rdata` = 0; FIFO pointers and count = 0.
- Asserting `reset` mid-operation drops all outstanding entries immediately. Pending writes are lost, and no `data_ok` is issued for them.
- For a request accepted in cycle N, `data_ok` is high in cycle N+LATENCY at the earliest. It is later only while older entries are still waiting.
- Throughput is one request per cycle sustained when `FIFO_DEPTH` > `LATENCY`. Otherwise acceptance stalls, and `addr_ok` drops while full.
- `rdata` is valid only in cycles where `data_ok` = 1 and the head is a read; at all other times it is driven 0.

## Configuration
- `DATA_SRAM_SLAVE_RAND_DELAY_EN` defined: random stalls are inserted using a 16-bit Fibonacci LFSR with taps 16,14,13,11, seeded 16'hACE1 on reset and advancing every cycle.
  - `addr_ok` = `~full & lfsr[0]`.
  - `data_ok` = `head_valid & (head.cnt == 0) & lfsr[1]`.
  - Ordering and the one-response-per-request guarantee are unchanged.
  - The reset value of `addr_ok` is `lfsr[0]` of the seed, which is 1.
- Undefined: fixed-latency behaviour exactly as described above; no LFSR is present.

## Test plan
- Reset preload: `mem[4]` = 32'h11223344; read at `addr` = 32'h10, `LATENCY` = 2, accepted in cycle 5 → `data_ok` and `rdata` = 32'h11223344 in cycle 7; `data_ok` = 0 in all other cycles.
- Byte write then read: write `addr` = 32'h13, `wstrb` = 4'b1000, `wdata` = 32'hAB000000, followed back-to-back by a read of 32'h10 → responses in order; the read returns 32'hAB223344.
- Full FIFO: with `FIFO_DEPTH` = 2 and `LATENCY` = 4, hold `req` high → `addr_ok` drops after two accepts and rises again the cycle after the first `data_ok`; the total count of `data_ok` equals the accept count.
- Wrap: with `ADDR_W` = 10, write 32'hDEADBEEF to `addr` = 32'h0000_1000 and read `addr` = 32'h0 → returns 32'hDEADBEEF.
- Reset mid-flight: accept 2 writes, then assert `reset` before either `data_ok` → no `data_ok` occurs; memory is unchanged; `addr_ok` = 1 after reset.
- With `DATA_SRAM_SLAVE_RAND_DELAY_EN` defined, run 1000 random transactions and check against a scoreboard → in-order data matches, and exactly one `data_ok` is returned per accept.
